// File: rtl/cryosram_pkg.sv
// Shared types and default widths for the cryogenic SRAM access sequencer.
package cryosram_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CF_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        SYNC,
        HOLD
    } state_e;

endpackage

// File: rtl/sram_access_seq_if.sv
// Device-side SRAM pin bundle: master drives address/data/strobes, slave returns read data.
interface sram_access_seq_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dout;
    logic [DATA_W-1:0] sram_din;
    logic              sram_ce_n;
    logic              sram_we_n;
    logic              sram_oe_n;

    modport master (
        output sram_addr, sram_dout, sram_ce_n, sram_we_n, sram_oe_n,
        input  sram_din
    );

    modport slave (
        input  sram_addr, sram_dout, sram_ce_n, sram_we_n, sram_oe_n,
        output sram_din
    );
endinterface

// File: rtl/phase_timer.sv
// Phase length counter: counts 0..limit, flags the last cycle; load restarts at 0.
module phase_timer #(
    parameter int CF_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [CF_W-1:0] limit,
    output logic            last
);
    logic [CF_W-1:0] r_cnt;

    // Reloaded on the last cycle, so limit = all-ones never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (load)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CF_W'(1);
    end

    assign last = (r_cnt == limit);
endmodule

// File: rtl/sram_access_seq.sv
// SRAM write/read strobe sequencer: SETUP/STROBE/HOLD of clk_factor+1 cycles each.
// Build option: CRYOSRAM_RDSYNC_EN adds a 2-flop read-data synchroniser and a SYNC phase.
module sram_access_seq #(
    parameter int ADDR_W = cryosram_pkg::ADDR_W,
    parameter int DATA_W = cryosram_pkg::DATA_W,
    parameter int CF_W   = cryosram_pkg::CF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    input  logic [CF_W-1:0]   clk_factor,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done
);
    import cryosram_pkg::*;

    state_e            r_state, w_next;
    logic [CF_W-1:0]   r_cf;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_is_wr;
    logic              r_busy;
    logic              r_done;
    logic              w_accept;
    logic              w_last;
    logic              w_load;
    logic [CF_W-1:0]   w_limit;
    logic              w_rd_load;
    logic [DATA_W-1:0] w_rd_src;

    assign w_limit = (r_state == SYNC) ? CF_W'(1) : r_cf;
    assign w_load  = (r_state == IDLE) || w_last;

    phase_timer #(.CF_W(CF_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .limit (w_limit),
        .last  (w_last)
    );

`ifdef CRYOSRAM_RDSYNC_EN
    logic [DATA_W-1:0] r_sync1, r_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sram_din;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rd_load = (r_state == SYNC) && w_last;
    assign w_rd_src  = r_sync2;
`else
    assign w_rd_load = (r_state == STROBE) && w_last && !r_is_wr;
    assign w_rd_src  = sram_din;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        sram_ce_n = 1'b1;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_dout = '0;
        case (r_state)
            IDLE: begin
                if (wr_req || rd_req) begin
                    w_accept = 1'b1;
                    w_next   = SETUP;
                end
            end
            SETUP:  if (w_last) w_next = STROBE;
            STROBE: begin
                if (w_last) begin
`ifdef CRYOSRAM_RDSYNC_EN
                    w_next = r_is_wr ? HOLD : SYNC;
`else
                    w_next = HOLD;
`endif
                end
            end
            SYNC:   if (w_last) w_next = HOLD;
            HOLD:   if (w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (r_state != IDLE) begin
            sram_ce_n = 1'b0;
            sram_we_n = !(r_is_wr && r_state == STROBE);
            sram_oe_n = r_is_wr;
            sram_dout = r_is_wr ? r_data : '0;
        end
    end

    // wr_req wins a same-cycle collision via r_is_wr <= wr_req.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cf      <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_is_wr   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= (r_state != IDLE) && (w_next == IDLE);
            if (w_accept) begin
                r_cf    <= clk_factor;
                r_addr  <= addr_in;
                r_data  <= wr_data_in;
                r_is_wr <= wr_req;
            end
            if (w_rd_load)
                r_rd_data <= w_rd_src;
        end
    end

    assign sram_addr = r_addr;
    assign rd_data   = r_rd_data;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule

// File: tb/tb_sram_access_seq.sv
// Directed bench for sram_access_seq; expectations follow CRYOSRAM_RDSYNC_EN when defined.
module tb_sram_access_seq;

`ifdef CRYOSRAM_RDSYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] addr_in = '0;
    logic [7:0] wr_data_in = '0;
    logic [7:0] clk_factor = '0;
    logic [7:0] rd_data;
    logic       busy, done;
    int         n_chk = 0;
    int         n_err = 0;

    sram_access_seq_if #(.ADDR_W(8), .DATA_W(8)) sif ();

    sram_access_seq #(.ADDR_W(8), .DATA_W(8), .CF_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .addr_in    (addr_in),
        .wr_data_in (wr_data_in),
        .clk_factor (clk_factor),
        .sram_addr  (sif.sram_addr),
        .sram_dout  (sif.sram_dout),
        .sram_din   (sif.sram_din),
        .sram_ce_n  (sif.sram_ce_n),
        .sram_we_n  (sif.sram_we_n),
        .sram_oe_n  (sif.sram_oe_n),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string pre, input logic [7:0] a);
        chk({pre, "_ce_n"}, 32'(sif.sram_ce_n), 1);
        chk({pre, "_we_n"}, 32'(sif.sram_we_n), 1);
        chk({pre, "_oe_n"}, 32'(sif.sram_oe_n), 1);
        chk({pre, "_dout"}, 32'(sif.sram_dout), 0);
        chk({pre, "_addr"}, 32'(a), 32'(sif.sram_addr) == 32'(a) ? 32'(a) : 32'hffff_ffff);
    endtask

    // One access from request to idle; counts strobe/busy cycles and pin stability.
    task automatic access(input string pre, input bit wr, input bit both, input bit chg,
                          input logic [7:0] cf, input logic [7:0] a, input logic [7:0] d);
        int n, eb, nb, nw, no, nd, bad, tmo;
        n = int'(cf) + 1;
        eb = wr ? 3 * n : 3 * n + SX;
        nb = 0; nw = 0; no = 0; nd = 0; bad = 0; tmo = 1;
        @(negedge clk);
        clk_factor = cf; addr_in = a; wr_data_in = d;
        wr_req = wr | both; rd_req = !wr | both;
        @(negedge clk);
        wr_req = 1'b0; rd_req = both;
        for (int c = 0; c < 2000; c++) begin
            if (!busy) begin
                tmo = 0;
                break;
            end
            nb++;
            if (!sif.sram_we_n) nw++;
            if (!sif.sram_oe_n) no++;
            if (done) nd++;
            if (!sif.sram_ce_n) begin
                if (sif.sram_addr !== a) bad++;
                if (sif.sram_dout !== (wr ? d : 8'h00)) bad++;
            end
            if (c == 1) begin
                rd_req = 1'b0;
                if (chg) begin
                    addr_in = 8'h11; clk_factor = 8'd1; wr_data_in = 8'h22;
                end
            end
            @(negedge clk);
        end
        chk({pre, "_timeout"}, 32'(tmo), 0);
        if (done) nd++;
        chk({pre, "_busy"}, 32'(nb), 32'(eb));
        chk({pre, "_we_lo"}, 32'(nw), wr ? 32'(n) : 0);
        chk({pre, "_oe_lo"}, 32'(no), wr ? 0 : 32'(eb));
        chk({pre, "_pins"}, 32'(bad), 0);
        chk({pre, "_done"}, 32'(nd), 1);
        @(negedge clk);
        chk({pre, "_done_post"}, 32'(done), 0);
        chk({pre, "_busy_post"}, 32'(busy), 0);
        chk_idle({pre, "_idle"}, a);
    endtask

    initial begin
        int tmo;
        sif.sram_din = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk_idle("rst", 8'h00);
        rst_n = 1'b1;

        access("wr_cf2", 1, 0, 0, 8'd2, 8'hcd, 8'hef);
        sif.sram_din = 8'hab;
        access("rd_cf2", 0, 0, 0, 8'd2, 8'h34, 8'h77);
        chk("rd_cf2_data", 32'(rd_data), 32'h0000_00ab);

        access("wr_cf0", 1, 0, 0, 8'd0, 8'h80, 8'h5a);
        sif.sram_din = 8'hff;
        access("rd_cf0", 0, 0, 0, 8'd0, 8'h80, 8'h00);
        chk("rd_cf0_data", 32'(rd_data), 32'h0000_00ff);

        // Collision: write wins, the follow-up read while busy is dropped.
        access("both", 1, 1, 0, 8'd2, 8'h42, 8'h99);
        repeat (4) @(negedge clk);
        chk("both_noqueue", 32'(busy), 0);
        chk("both_rd_hold", 32'(rd_data), 32'h0000_00ff);

        access("latch", 1, 0, 1, 8'd2, 8'h55, 8'h66);
        access("latch_next", 1, 0, 0, 8'd1, 8'h11, 8'h22);

        access("wr_cfmax", 1, 0, 0, 8'hff, 8'h3c, 8'ha5);

        // Reset in the middle of a write strobe.
        @(negedge clk);
        clk_factor = 8'd2; addr_in = 8'h77; wr_data_in = 8'h88; wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        tmo = 1;
        for (int c = 0; c < 100; c++) begin
            if (!sif.sram_we_n) begin
                tmo = 0;
                break;
            end
            @(negedge clk);
        end
        chk("midrst_timeout", 32'(tmo), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ce_n", 32'(sif.sram_ce_n), 1);
        chk("midrst_we_n", 32'(sif.sram_we_n), 1);
        chk("midrst_oe_n", 32'(sif.sram_oe_n), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        access("postrst", 1, 0, 0, 8'd1, 8'h21, 8'h43);

        // Request coinciding with reset is dropped.
        @(negedge clk);
        rst_n = 1'b0; rd_req = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; rd_req = 1'b0;
        @(negedge clk);
        chk("rstreq_busy", 32'(busy), 0);
        chk("rstreq_ce_n", 32'(sif.sram_ce_n), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sram_access_seq.md
SRAM_ACCESS_SEQ -- requirements
Module: sram_access_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, SRAM data width.
REQ-003 SHALL have parameter CF_W, default 8, clk_factor width.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports wr_req / rd_req  input  1 each  single-cycle access request pulses from the debounced buttons.
REQ-007 SHALL have ports addr_in  input  ADDR_W and wr_data_in  input  DATA_W  access address and write value.
REQ-008 SHALL have port clk_factor  input  CF_W  phase length minus one, in clk cycles.
REQ-009 SHALL have ports sram_addr  output  ADDR_W and sram_dout  output  DATA_W  address and write-data pins to the device.
REQ-010 SHALL have port sram_din  input  DATA_W  read-data pins from the device.
REQ-011 SHALL have ports sram_ce_n, sram_we_n, sram_oe_n  output  1 each  active-low device strobes.
REQ-012 SHALL have ports rd_data  output  DATA_W, busy  output  1, done  output  1  last read value, access in progress, one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, STROBE, SYNC, HOLD.
REQ-014 SHALL define phase length N = clk_factor+1 cycles; SETUP, STROBE and HOLD each last exactly N cycles; clk_factor=0 gives N=1.
REQ-015 SHALL latch clk_factor, addr_in and wr_data_in on request acceptance; later input changes SHALL NOT affect the access in progress.
REQ-016 SHALL accept a request only in IDLE; busy SHALL rise on the edge after acceptance and stay high until the return to IDLE.
REQ-017 SHALL ignore wr_req or rd_req while busy; no queuing.
REQ-018 SHALL give wr_req priority when wr_req and rd_req are asserted in the same cycle.
REQ-019 Write: sram_ce_n=0 in SETUP, STROBE and HOLD; sram_we_n=0 only in STROBE; sram_oe_n=1 throughout; sram_dout=latched data in all three states.
REQ-020 Read: sram_ce_n=0 and sram_oe_n=0 in SETUP, STROBE, SYNC and HOLD; sram_we_n=1 throughout; sram_dout=0.
REQ-021 SHALL load rd_data on the last clock edge of STROBE when RDSYNC is absent, or of SYNC when RDSYNC is present; rd_data SHALL otherwise hold its value.
REQ-022 SHALL skip SYNC on writes, and on reads when RDSYNC is absent.
REQ-023 SHALL pulse done high for exactly one cycle on the edge entering IDLE; busy SHALL fall on that same edge.
REQ-024 In IDLE: sram_ce_n, sram_we_n and sram_oe_n SHALL be 1; sram_dout SHALL be 0; sram_addr SHALL hold the last latched address.
REQ-025 The phase counter SHALL count from 0 to the latched clk_factor with no overflow; clk_factor at its maximum (2^CF_W-1) gives N=2^CF_W.

Reset
REQ-026 When rst_n=0 at a clock edge, the next state SHALL be IDLE, from any state including mid-access.
REQ-027 Reset values: sram_ce_n=1, sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_dout=0, rd_data=0, busy=0, done=0, phase counter=0.
REQ-028 A request coinciding with rst_n=0 SHALL be dropped.

Configuration
REQ-029 Macro CRYOSRAM_RDSYNC_EN SHALL control read-data synchronisation.
- Defined: sram_din passes through a 2-flop synchroniser; SYNC lasts exactly 2 cycles; read busy time = 3N+2.
- Undefined: no synchroniser; sram_din is sampled directly; read busy time = 3N.
- Write timing SHALL be identical in both builds.

Structure
REQ-030 Package cryosram_pkg SHALL hold the state enum and the default width constants ADDR_W, DATA_W and CF_W.
REQ-031 Sub-module phase_timer SHALL contain the N-cycle counter: inputs load and limit, output last-cycle flag.

Verification
REQ-032 clk_factor=2, addr=0xcd, data=0xef, wr_req -> sram_we_n low exactly 3 cycles; sram_addr=0xcd and sram_dout=0xef throughout; busy 9 cycles; one done pulse.
REQ-033 sram_din=0xab, rd_req, clk_factor=2 -> rd_data=0xab; sram_oe_n low 9 cycles (11 with CRYOSRAM_RDSYNC_EN); sram_we_n stays high.
REQ-034 clk_factor=0, write then read at addr 0x80 with sram_din=0xff -> each phase 1 cycle; rd_data=0xff.
REQ-035 wr_req and rd_req in the same cycle, then rd_req while busy -> only the write executes; exactly one done pulse.
REQ-036 rst_n low during write STROBE -> next edge: all strobes high, busy=0, rd_data=0; a new request after rst_n=1 completes normally.
REQ-037 Change addr_in and clk_factor mid-access -> the current access uses the latched values; the next access uses the new ones.
